// File: rtl/vga_timing_gen.sv
// vga_timing_gen: clock-enabled VGA timing, frame-buffer addressing and colour output
module vga_timing_gen #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP = 16,
  parameter int H_SYNC = 96,
  parameter int H_BP = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP = 10,
  parameter int V_SYNC = 2,
  parameter int V_BP = 33,
  parameter bit HS_POL = 1'b0,
  parameter bit VS_POL = 1'b0,
  parameter int CLK_DIV = 2,
  parameter int SCALE_SHIFT = 0,
  parameter int MEM_LAT = 1,
  parameter int ADDR_W = 32
) (
  input  logic              clk50MHz,
  input  logic              rst_n,
  input  logic              mode,
  input  logic [7:0]        memPx,
  output logic              pix_en,
  output logic [ADDR_W-1:0] px_addr,
  output logic              px_rd,
  output logic              vga_hsync,
  output logic              vga_vsync,
  output logic              vga_blank_n,
  output logic [7:0]        vga_red,
  output logic [7:0]        vga_green,
  output logic [7:0]        vga_blue,
  output logic              frame_start
);
  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int IMG_W = H_ACTIVE >> SCALE_SHIFT;
  localparam int HW = $clog2(H_TOTAL + 1);
  localparam int VW = $clog2(V_TOTAL + 1);
  localparam int DW = CLK_DIV > 1 ? $clog2(CLK_DIV) : 1;
  localparam logic [DW-1:0] D_END = DW'(CLK_DIV - 1);
  logic [DW-1:0] div;
  logic [HW-1:0] hcnt;
  logic [VW-1:0] vcnt;
  logic active, hs_raw, vs_raw, h_end, wrap, mode_q;
  logic [ADDR_W-1:0] addr_n;
  // {active, hsync, vsync}; slot 0 is aligned with px_addr, slot MEM_LAT with memPx
  logic [MEM_LAT:0][2:0] dl;
  logic [2:0] tail;
  logic [23:0] rgb;
  assign h_end = hcnt == HW'(H_TOTAL - 1);
  assign wrap = h_end && (vcnt == VW'(V_TOTAL - 1));
  assign active = (hcnt < HW'(H_ACTIVE)) && (vcnt < VW'(V_ACTIVE));
  assign hs_raw = (hcnt >= HW'(H_ACTIVE + H_FP) && hcnt < HW'(H_ACTIVE + H_FP + H_SYNC)) ? HS_POL : ~HS_POL;
  assign vs_raw = (vcnt >= VW'(V_ACTIVE + V_FP) && vcnt < VW'(V_ACTIVE + V_FP + V_SYNC)) ? VS_POL : ~VS_POL;
  assign addr_n = ADDR_W'(vcnt >> SCALE_SHIFT) * ADDR_W'(IMG_W) + ADDR_W'(hcnt >> SCALE_SHIFT);
  assign tail = dl[MEM_LAT];
  assign rgb = mode_q ? {memPx[7:5], memPx[7:5], memPx[7:6], memPx[4:2], memPx[4:2], memPx[4:3], {4{memPx[1:0]}}}
                      : {3{memPx}};
  always_ff @(posedge clk50MHz or negedge rst_n)
    if (!rst_n) begin
      div <= '0;
      pix_en <= 1'b0;
      hcnt <= '0;
      vcnt <= '0;
      px_addr <= '0;
      px_rd <= 1'b0;
      dl <= {(MEM_LAT + 1){{1'b0, ~HS_POL, ~VS_POL}}};
      mode_q <= 1'b0;
      frame_start <= 1'b0;
      vga_hsync <= ~HS_POL;
      vga_vsync <= ~VS_POL;
      vga_blank_n <= 1'b0;
      {vga_red, vga_green, vga_blue} <= '0;
    end else begin
      div <= div == D_END ? '0 : div + 1'b1;
      pix_en <= div == D_END;
      frame_start <= pix_en && wrap;
      if (pix_en) begin
        hcnt <= h_end ? '0 : hcnt + 1'b1;
        if (h_end) vcnt <= wrap ? '0 : vcnt + 1'b1;
        if (wrap) mode_q <= mode;
        if (active) px_addr <= addr_n;
        px_rd <= active;
        dl[0] <= {active, hs_raw, vs_raw};
        for (int i = 1; i <= MEM_LAT; i++) dl[i] <= dl[i-1];
        vga_blank_n <= tail[2];
        vga_hsync <= tail[1];
        vga_vsync <= tail[0];
        {vga_red, vga_green, vga_blue} <= tail[2] ? rgb : '0;
      end
    end
endmodule
